uart_tx_sched: RTL and testbench

- Shares the single UART transmitter between NUM_REQ requesters (one per hart, or hart plus debug port) through a byte FIFO and a round-robin arbiter.
- Sits between the MMIO decode in the IO block and the UART TX shifter.
- Sequences the shifter with a start/busy handshake so a byte is never launched while the shifter is busy.
- Per-requester byte order is preserved; software no longer needs to poll busy before every store.

---
 rtl/uart_tx_sched_pkg.sv | 21 ++
 rtl/uart_tx_sched_if.sv | 25 ++
 rtl/uart_tx_sched_fifo.sv | 62 ++++++
 rtl/uart_tx_sched.sv | 153 +++++++++++++++
 tb/tb_uart_tx_sched.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_sched_pkg.sv
// Shared constants for the UART TX scheduler: drain FSM states,
// byte width, MMIO address and status-bit positions.
package uart_sched_pkg;

    localparam int UART_BYTE_W = 8;

    localparam logic [31:0] IO_BASE_ADDR      = 32'h1000_0000;
    localparam logic [31:0] IO_UART_TX_OFFSET = 32'h0000_0000;
    localparam logic [31:0] UART_SCHED_ADDR   =
        IO_BASE_ADDR + IO_UART_TX_OFFSET;

    // Bit positions in the IO status read word
    localparam int UART_STAT_SCHED_BUSY_BIT = 0;
    localparam int UART_STAT_LEVEL_LSB      = 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LAUNCH  = 2'd1;
    localparam logic [1:0] ST_WAIT_HI = 2'd2;
    localparam logic [1:0] ST_WAIT_LO = 2'd3;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester and shifter handshake bundle for uart_tx_sched.
// master = scheduler side, slave = requesters plus TX shifter.
interface uart_tx_sched_if #(
    parameter int NUM_REQ = 2
);
    import uart_sched_pkg::*;

    logic [NUM_REQ-1:0]             req_valid;
    logic [UART_BYTE_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]             req_ready;
    logic                           tx_start;
    logic [UART_BYTE_W-1:0]         tx_data;
    logic                           tx_busy;

    modport master (
        input  req_valid, req_data, tx_busy,
        output req_ready, tx_start, tx_data
    );

    modport slave (
        output req_valid, req_data, tx_busy,
        input  req_ready, tx_start, tx_data
    );

endinterface

// File: rtl/uart_tx_sched_fifo.sv
// sync_byte_fifo: single-clock byte FIFO, power-of-two depth,
// one push and one pop per cycle, guarded against over/underflow.
module sync_byte_fifo
    import uart_sched_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [UART_BYTE_W-1:0] wdata,
    output logic [UART_BYTE_W-1:0] rdata,
    output logic                   full,
    output logic                   empty,
    output logic [LVL_W-1:0]       level
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [UART_BYTE_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic                   do_push, do_pop;

    assign full    = level_q == LVL_W'(DEPTH);
    assign empty   = level_q == '0;
    assign level   = level_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        level_d  = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin share of one UART TX shifter between NUM_REQ requesters.
// Optional stats counters: define UART_TX_SCHED_STATS_EN.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_sched_if.master  bus,
    output logic [LVL_W-1:0] fifo_level,
    output logic             sched_busy
`ifdef UART_TX_SCHED_STATS_EN
    ,
    output logic [16*NUM_REQ-1:0] stat_bytes,
    output logic [15:0]           stat_bp
`endif
);
    localparam int RR_W = $clog2(NUM_REQ);

    logic [RR_W-1:0]        rr_q, rr_d;
    logic [1:0]             state_q, state_d;
    logic [UART_BYTE_W-1:0] tx_data_q, tx_data_d;

    logic [NUM_REQ-1:0]     grant;
    logic [RR_W-1:0]        gnt_idx;
    logic                   any_gnt;
    logic [UART_BYTE_W-1:0] push_data;
    logic [UART_BYTE_W-1:0] fifo_rdata;
    logic                   fifo_full, fifo_empty;
    logic                   pop;

    sync_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (any_gnt),
        .pop   (pop),
        .wdata (push_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Full is judged on the registered level only: no pop bypass
    always_comb begin : arb
        int              idx;
        logic [RR_W-1:0] sel;
        grant   = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        idx     = 0;
        sel     = '0;
        if (!rst && !fifo_full) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(rr_q) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                sel = RR_W'(idx);
                if (!any_gnt && bus.req_valid[sel]) begin
                    any_gnt    = 1'b1;
                    grant[sel] = 1'b1;
                    gnt_idx    = sel;
                end
            end
        end
    end

    always_comb begin
        push_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i])
                push_data = bus.req_data[i*UART_BYTE_W +: UART_BYTE_W];
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (any_gnt)
            rr_d = (gnt_idx == RR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !bus.tx_busy) begin
                    pop       = 1'b1;
                    tx_data_d = fifo_rdata;
                    state_d   = ST_LAUNCH;
                end
            end
            ST_LAUNCH:  state_d = ST_WAIT_HI;
            ST_WAIT_HI: if (bus.tx_busy) state_d = ST_WAIT_LO;
            ST_WAIT_LO: if (!bus.tx_busy) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q      <= '0;
            state_q   <= ST_IDLE;
            tx_data_q <= '0;
        end else begin
            rr_q      <= rr_d;
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign bus.req_ready = grant;
    assign bus.tx_start  = state_q == ST_LAUNCH;
    assign bus.tx_data   = tx_data_q;
    assign sched_busy    = !fifo_empty || (state_q != ST_IDLE);

`ifdef UART_TX_SCHED_STATS_EN
    logic [15:0] cnt_q [NUM_REQ];
    logic [15:0] cnt_d [NUM_REQ];
    logic [15:0] bp_q, bp_d;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            cnt_d[i] = cnt_q[i] + {15'd0, grant[i]};
        bp_d = bp_q + {15'd0, (|bus.req_valid) & fifo_full};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
            bp_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
            bp_q <= bp_d;
        end
    end

    always_comb begin
        stat_bytes = '0;
        for (int i = 0; i < NUM_REQ; i++)
            stat_bytes[i*16 +: 16] = cnt_q[i];
    end

    assign stat_bp = bp_q;
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: arbitration table, directed
// corner sequences and random traffic against a queue-based model.
module tb_uart_tx_sched;
    import uart_sched_pkg::*;

    localparam int NR    = 2;
    localparam int DEPTH = 8;
    localparam int LW    = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_sched_if #(.NUM_REQ(NR)) bus ();
    logic [LW-1:0] fifo_level;
    logic          sched_busy;
`ifdef UART_TX_SCHED_STATS_EN
    logic [16*NR-1:0] stat_bytes;
    logic [15:0]      stat_bp;
`endif

    uart_tx_sched #(
        .NUM_REQ    (NR),
        .FIFO_DEPTH (DEPTH),
        .LVL_W      (LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .fifo_level (fifo_level),
        .sched_busy (sched_busy)
`ifdef UART_TX_SCHED_STATS_EN
        ,
        .stat_bytes (stat_bytes),
        .stat_bp    (stat_bp)
`endif
    );

    int total = 0;
    int bad   = 0;

    // drive variables
    logic [NR-1:0]   v_valid;
    logic [8*NR-1:0] v_data;
    bit              v_rst;
    bit              stream_on;
    int              src [NR][$];

    // shifter model
    bit stuck;
    bit rand_mode;
    int busy_cnt;
    int busy_len;

    // reference model
    int         mq[$];
    int         rr_m;
    bit         inflight, saw_hi, launch_pend;
    logic [7:0] last_pop;
    int         acc_cnt [NR];
    int         bp_cnt;

    // observation
    int         launched[$];
    int         grants[$];
    int         cyc;
    int         last_fall;
    bit         prev_busy;
    logic [NR-1:0] s_ready;
    logic [LW-1:0] s_level;
    logic       s_start, s_sched, s_busy;
    logic [7:0] s_data;

    typedef struct {
        logic [NR-1:0]   valid;
        logic [8*NR-1:0] data;
        logic [NR-1:0]   exp_ready;
        int              exp_level;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        rr_m = 0;
        inflight = 0;
        saw_hi = 0;
        launch_pend = 0;
        last_pop = '0;
        for (int i = 0; i < NR; i++) acc_cnt[i] = 0;
        bp_cnt = 0;
    endtask

    task automatic cycle();
        int         g;
        int         idx;
        bit         do_pop;
        logic [NR-1:0] exp_rdy;
        @(posedge clk);
        #1;
        if (stream_on) begin
            for (int i = 0; i < NR; i++) begin
                v_valid[i] = src[i].size() > 0;
                v_data[i*8 +: 8] = (src[i].size() > 0) ? src[i][0][7:0] : 8'h00;
            end
        end
        rst           = v_rst;
        bus.req_valid = v_valid;
        bus.req_data  = v_data;
        bus.tx_busy   = stuck || (busy_cnt > 0);
        #1;
        cyc++;
        s_ready = bus.req_ready;
        s_level = fifo_level;
        s_start = bus.tx_start;
        s_data  = bus.tx_data;
        s_sched = sched_busy;
        s_busy  = bus.tx_busy;
        if (prev_busy && !s_busy) last_fall = cyc;
        prev_busy = s_busy;
        if (s_start) launched.push_back(int'(s_data));
        for (int i = 0; i < NR; i++)
            if (s_ready[i] && v_valid[i]) grants.push_back(i);
        if (s_start) busy_cnt = rand_mode ? int'($urandom_range(1, 6)) : busy_len;
        else if (busy_cnt > 0) busy_cnt--;
        if (v_rst) begin
            model_reset();
            return;
        end
        g = -1;
        if (mq.size() < DEPTH) begin
            for (int k = 0; k < NR; k++) begin
                idx = (rr_m + k) % NR;
                if (g < 0 && v_valid[idx]) g = idx;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("ready", s_ready, exp_rdy);
        chk("level", s_level, mq.size());
        chk("sched_busy", s_sched, (mq.size() != 0) || inflight);
        chk("tx_start", s_start, launch_pend);
        chk("start_while_busy", s_start & s_busy, 0);
        if (s_start) chk("tx_data", s_data, last_pop);
        if ((|v_valid) && mq.size() == DEPTH) bp_cnt++;
        do_pop = !inflight && mq.size() > 0 && !s_busy;
        if (!launch_pend) begin
            if (inflight && !saw_hi && s_busy) saw_hi = 1;
            else if (inflight && saw_hi && !s_busy) begin
                inflight = 0;
                saw_hi = 0;
            end
        end
        launch_pend = 0;
        if (do_pop) begin
            last_pop = 8'(mq.pop_front());
            inflight = 1;
            saw_hi = 0;
            launch_pend = 1;
        end
        if (g >= 0) begin
            mq.push_back(int'(v_data[g*8 +: 8]));
            rr_m = (g + 1) % NR;
            acc_cnt[g]++;
            if (stream_on && src[g].size() > 0) void'(src[g].pop_front());
        end
    endtask

    task automatic drain(input string nm, input int want);
        int n = 0;
        while ((launched.size() < want || s_sched) && n < 3000) begin
            cycle();
            n++;
        end
        chk({nm, "_launches"}, launched.size(), want);
        chk({nm, "_level0"}, s_level, 0);
    endtask

`ifdef UART_TX_SCHED_STATS_EN
    task automatic chk_stats();
        for (int i = 0; i < NR; i++)
            chk($sformatf("stat_bytes%0d", i), stat_bytes[i*16 +: 16],
                acc_cnt[i]);
        chk("stat_bp", stat_bp, bp_cnt);
    endtask
`endif

    vec_t vt[11];
    int   exp_order[$];
    int   fall_cyc;
    int   na, nb, ea, eb;

    initial begin
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_data = '0;
        bus.tx_busy = 1'b0;
        v_valid = '0;
        v_data = '0;
        v_rst = 1;
        stream_on = 0;
        stuck = 0;
        rand_mode = 0;
        busy_cnt = 0;
        busy_len = 20;
        cyc = 0;
        last_fall = 0;
        prev_busy = 0;
        model_reset();

        vt[0]  = '{2'b01, 16'h5040, 2'b01, 0};
        vt[1]  = '{2'b11, 16'h5141, 2'b10, 1};
        vt[2]  = '{2'b11, 16'h5242, 2'b01, 2};
        vt[3]  = '{2'b10, 16'h5343, 2'b10, 3};
        vt[4]  = '{2'b01, 16'h5444, 2'b01, 4};
        vt[5]  = '{2'b00, 16'h5545, 2'b00, 5};
        vt[6]  = '{2'b01, 16'h5646, 2'b01, 5};
        vt[7]  = '{2'b11, 16'h5747, 2'b10, 6};
        vt[8]  = '{2'b11, 16'h5848, 2'b01, 7};
        vt[9]  = '{2'b11, 16'h5949, 2'b00, 8};
        vt[10] = '{2'b10, 16'h5a4a, 2'b00, 8};

        cycle();
        cycle();
        v_rst = 0;
        cycle();
        chk("rst_level", s_level, 0);
        chk("rst_ready", s_ready, 0);
        chk("rst_start", s_start, 0);
        chk("rst_txdata", s_data, 0);
        chk("rst_sched", s_sched, 0);

        // single requester, 16 bytes, 20-cycle shifter
        for (int i = 0; i < 16; i++) src[0].push_back((i * 8'h11) & 8'hff);
        launched.delete();
        stream_on = 1;
        drain("t1", 16);
        fall_cyc = cyc;
        stream_on = 0;
        v_valid = '0;
        for (int i = 0; i < 16; i++)
            chk($sformatf("t1_byte%0d", i),
                (i < launched.size()) ? launched[i] : -1, (i * 8'h11) & 8'hff);
        chk("t1_sched_fall", fall_cyc, last_fall + 1);

        // contention: both streams held valid
        for (int i = 0; i < 8; i++) begin
            src[0].push_back(8'hA0 + i);
            src[1].push_back(8'hB0 + i);
        end
        launched.delete();
        grants.delete();
        stream_on = 1;
        drain("t2", 16);
        stream_on = 0;
        v_valid = '0;
        chk("t2_grants", grants.size(), 16);
        for (int i = 1; i < grants.size(); i++)
            chk($sformatf("t2_alt%0d", i), grants[i] != grants[i-1], 1);
        na = 0;
        nb = 0;
        ea = 0;
        eb = 0;
        foreach (launched[i]) begin
            if (launched[i][7:4] == 4'hA) begin
                if (launched[i] != 8'hA0 + na) ea++;
                na++;
            end else begin
                if (launched[i] != 8'hB0 + nb) eb++;
                nb++;
            end
        end
        chk("t2_cnt_a", na, 8);
        chk("t2_cnt_b", nb, 8);
        chk("t2_order_a", ea, 0);
        chk("t2_order_b", eb, 0);

        // full FIFO: busy stuck high, table of arbitration vectors
        stuck = 1;
        exp_order.delete();
        for (int i = 0; i < 11; i++) begin
            v_valid = vt[i].valid;
            v_data = vt[i].data;
            cycle();
            chk($sformatf("tbl%0d_ready", i), s_ready, vt[i].exp_ready);
            chk($sformatf("tbl%0d_level", i), s_level, vt[i].exp_level);
            for (int r = 0; r < NR; r++)
                if (vt[i].exp_ready[r]) exp_order.push_back(int'(vt[i].data[r*8 +: 8]));
        end
        v_valid = '0;
        cycle();
        chk("t3_level8", s_level, 8);
        chk("t3_ready0", s_ready, 0);
        chk("t3_accepted", exp_order.size(), 8);
`ifdef UART_TX_SCHED_STATS_EN
        chk_stats();
`endif
        launched.delete();
        stuck = 0;
        drain("t3", 8);
        for (int i = 0; i < exp_order.size(); i++)
            chk($sformatf("t3_byte%0d", i),
                (i < launched.size()) ? launched[i] : -1, exp_order[i]);

        // push and pop in the same cycle at level 3
        stuck = 1;
        for (int i = 0; i < 3; i++) begin
            v_valid = 2'b01;
            v_data = {8'h00, 8'h31 + 8'(i)};
            cycle();
        end
        stuck = 0;
        v_valid = 2'b01;
        v_data = 16'h0034;
        cycle();
        chk("t4_level_pre", s_level, 3);
        chk("t4_ready", s_ready, 2'b01);
        v_valid = '0;
        cycle();
        chk("t4_level_post", s_level, 3);
        chk("t4_start", s_start, 1);
        chk("t4_oldest", s_data, 8'h31);
        launched.delete();
        drain("t4", 3);

        // reset in WAIT_LO with five bytes queued
        for (int i = 0; i < 6; i++) src[0].push_back(8'h51 + i);
        stream_on = 1;
        for (int n = 0; n < 50 && src[0].size() > 0; n++) cycle();
        stream_on = 0;
        v_valid = '0;
        for (int i = 0; i < 3; i++) cycle();
        chk("t5_level_pre", s_level, 5);
        chk("t5_busy_pre", s_busy, 1);
        v_rst = 1;
        cycle();
        v_rst = 0;
        cycle();
        chk("t5_level", s_level, 0);
        chk("t5_start", s_start, 0);
        chk("t5_ready", s_ready, 0);
        chk("t5_sched", s_sched, 0);
        launched.delete();
        for (int i = 0; i < 60; i++) cycle();
        chk("t5_no_stale", launched.size(), 0);

        // random traffic
        v_rst = 1;
        cycle();
        v_rst = 0;
        rand_mode = 1;
        for (int i = 0; i < 1500; i++) begin
            v_valid = NR'($urandom);
            v_data = 16'($urandom);
            cycle();
        end
        v_valid = '0;
        for (int n = 0; n < 3000 && s_sched; n++) cycle();
        chk("rand_idle", s_sched, 0);
        chk("rand_level", s_level, 0);
`ifdef UART_TX_SCHED_STATS_EN
        chk_stats();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
